// File: rtl/wb_block_initiator_if.sv
// Bus bundle for wb_block_initiator: command, write/read streams and the
// Wishbone initiator signals. master = initiator side, slave = harness side.
interface wb_block_initiator_if #(
    parameter int AW    = 32,
    parameter int CNT_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [AW-1:0]    cmd_addr;
    logic [CNT_W-1:0] cmd_count;
    logic [3:0]       cmd_sel;
    logic             wdat_valid;
    logic             wdat_ready;
    logic [31:0]      wdat;
    logic             rdat_valid;
    logic             rdat_ready;
    logic [31:0]      rdat;
    logic             done;
    logic             error;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [AW-1:0]    wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic             wbm_ack_i;
    logic [31:0]      wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_count, cmd_sel,
        input  wdat_valid, wdat, rdat_ready, wbm_ack_i, wbm_dat_i,
        output cmd_ready, wdat_ready, rdat_valid, rdat, done, error,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_count, cmd_sel,
        output wdat_valid, wdat, rdat_ready, wbm_ack_i, wbm_dat_i,
        input  cmd_ready, wdat_ready, rdat_valid, rdat, done, error,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_block_initiator.sv
// Wishbone classic-cycle block initiator: one beat per bus cycle.
// Define WB_INIT_TIMEOUT_EN to abort a beat after TIMEOUT_CYC cycles.
module wb_block_initiator #(
    parameter int AW          = 32,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    wb_block_initiator_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_PUSH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    adr_q,   adr_d;
    logic [31:0]      dat_q,   dat_d;
    logic             we_q,    we_d;
    logic [3:0]       sel_q,   sel_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [31:0]      rdat_q,  rdat_d;
    logic             rvld_q,  rvld_d;

`ifdef WB_INIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    // Next-state logic: command accept, beat sequencing, stream handshakes
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        rdat_d  = rdat_q;
        rvld_d  = rvld_q;
`ifdef WB_INIT_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    we_d  = bus.cmd_we;
                    sel_d = bus.cmd_sel;
                    adr_d = {bus.cmd_addr[AW-1:2], 2'b00};
                    rem_d = bus.cmd_count;
`ifdef WB_INIT_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (bus.cmd_count == '0)
                        state_d = S_DONE;
                    else if (bus.cmd_we)
                        state_d = S_FETCH;
                    else
                        state_d = S_REQ;
                end
            end
            S_FETCH: begin
                if (bus.wdat_valid) begin
                    dat_d   = bus.wdat;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.wbm_ack_i) begin
                    adr_d = adr_q + AW'(4);
                    rem_d = rem_q - CNT_W'(1);
                    if (we_q) begin
                        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FETCH;
                    end else begin
                        rdat_d  = bus.wbm_dat_i;
                        rvld_d  = 1'b1;
                        state_d = S_PUSH;
                    end
                end
`ifdef WB_INIT_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_PUSH: begin
                if (bus.rdat_ready) begin
                    rvld_d  = 1'b0;
                    state_d = (rem_q == '0) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any block in flight
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rem_q   <= '0;
            rdat_q  <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            rdat_q  <= rdat_d;
            rvld_q  <= rvld_d;
        end
    end

`ifdef WB_INIT_TIMEOUT_EN
    // Ack watchdog: counter restarts on every fresh strobe
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    // Address bits [1:0] are ignored (word aligned)
    logic unused_ok;
    assign unused_ok = ^{bus.cmd_addr[1:0], (TIMEOUT_CYC > 0)};

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.wdat_ready = (state_q == S_FETCH);
    assign bus.wbm_cyc_o  = (state_q == S_REQ);
    assign bus.wbm_stb_o  = (state_q == S_REQ);
    assign bus.wbm_we_o   = we_q;
    assign bus.wbm_sel_o  = sel_q;
    assign bus.wbm_adr_o  = adr_q;
    assign bus.wbm_dat_o  = dat_q;
    assign bus.rdat       = rdat_q;
    assign bus.rdat_valid = rvld_q;
    assign bus.done       = (state_q == S_DONE);

endmodule
